mem_io_responder: RTL



---
 rtl/mem_io_responder_if.sv | 29 ++
 rtl/mem_io_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder_if.sv
// Bus bundle between the CPU/host side and the memory/I-O responder.
// Carries the CPU byte bus, the host input stream, the output stream and
// the program-stop flag.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        cpu_rdy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt;

  // CPU core plus UART/host side
  modport master (
    output mem_a, mem_dout, mem_wr, rx_data, rx_valid, tx_ready,
    input  mem_din, cpu_rdy, rx_ready, tx_data, tx_valid, halt
  );

  // Responder side
  modport slave (
    input  mem_a, mem_dout, mem_wr, rx_data, rx_valid, tx_ready,
    output mem_din, cpu_rdy, rx_ready, tx_data, tx_valid, halt
  );
endinterface

// File: rtl/mem_io_responder.sv
// Byte-wide memory bus responder: on-chip RAM, input/output byte FIFOs,
// free-running cycle counter with snapshot, and sticky program stop.
// I/O window is mem_a[17:16]==2'b11; everything else maps to RAM.
module mem_io_responder #(
  parameter int RAM_AW  = 17,
  parameter int FIFO_AW = 3
) (
  input logic            clk_in,
  input logic            rst_in,
  mem_io_responder_if.slave bus
);
  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW+1)'(1);

  // Storage (no reset: contents are don't-care until written / pointed at)
  logic [7:0] ram_q    [0:(1<<RAM_AW)-1];
  logic [7:0] rx_mem_q [0:FIFO_DEPTH-1];
  logic [7:0] tx_mem_q [0:FIFO_DEPTH-1];
  logic [7:0] ram_rd_q;

  // Control state
  logic [FIFO_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [FIFO_AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [FIFO_AW:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [23:0]        snap_q, snap_d;
  logic               halt_q, halt_d;
  logic [7:0]         io_din_q, io_din_d;
  logic               din_sel_q, din_sel_d;

  // Decode and handshake terms
  logic [17:0]        addr_s;
  logic [15:0]        io_off_s;
  logic [RAM_AW-1:0]  ram_addr_s;
  logic               is_io_s;
  logic               rx_full_s, rx_empty_s, tx_full_s, tx_empty_s;
  logic               cpu_rdy_s, rx_ready_s;
  logic               acc_rd_s, acc_wr_s, ram_we_s, ram_re_s;
  logic               rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
  logic [7:0]         tx_push_data_s;
  logic               unused_addr_s;

  assign addr_s        = bus.mem_a[17:0];
  assign unused_addr_s = ^bus.mem_a[31:18];
  assign io_off_s      = addr_s[15:0];
  assign ram_addr_s    = bus.mem_a[RAM_AW-1:0];
  assign is_io_s       = (addr_s[17:16] == 2'b11);

  // Count MSB is set only when the FIFO holds exactly FIFO_DEPTH bytes
  assign rx_full_s  = rx_cnt_q[FIFO_AW];
  assign tx_full_s  = tx_cnt_q[FIFO_AW];
  assign rx_empty_s = (rx_cnt_q == '0);
  assign tx_empty_s = (tx_cnt_q == '0);

  // Gated with the reset pin so both read 0 while reset is held
  assign cpu_rdy_s  = rst_in & ~tx_full_s;
  assign rx_ready_s = rst_in & ~rx_full_s;

  assign acc_rd_s = cpu_rdy_s & ~bus.mem_wr;
  assign acc_wr_s = cpu_rdy_s &  bus.mem_wr;
  assign ram_we_s = acc_wr_s & ~is_io_s;
  assign ram_re_s = acc_rd_s & ~is_io_s;

  assign rx_push_s = bus.rx_valid & rx_ready_s;
  // An empty FIFO never pops, so a same-cycle push is not bypassed
  assign rx_pop_s  = acc_rd_s & is_io_s & (io_off_s == 16'h0000) & ~rx_empty_s;
  assign tx_pop_s  = ~tx_empty_s & bus.tx_ready;
  // Data 0x00 to the output port is dropped; stop pushes a 0x00 terminator
  assign tx_push_s = acc_wr_s & is_io_s &
                     (((io_off_s == 16'h0000) & (bus.mem_dout != 8'h00)) |
                      (io_off_s == 16'h0004));
  assign tx_push_data_s = (io_off_s == 16'h0004) ? 8'h00 : bus.mem_dout;

  assign bus.cpu_rdy  = cpu_rdy_s;
  assign bus.rx_ready = rx_ready_s;
  assign bus.tx_valid = ~tx_empty_s;
  assign bus.tx_data  = tx_empty_s ? 8'h00 : tx_mem_q[tx_rp_q];
  assign bus.halt     = halt_q;
  // RAM reads come from the RAM output register, I/O reads from io_din_q
  assign bus.mem_din  = din_sel_q ? ram_rd_q : io_din_q;

  // RAM array write and registered read (block-RAM friendly, no reset)
  always_ff @(posedge clk_in) begin
    if (ram_we_s) begin
      ram_q[ram_addr_s] <= bus.mem_dout;
    end
    if (ram_re_s) begin
      ram_rd_q <= ram_q[ram_addr_s];
    end
  end

  // FIFO data arrays; pointers alone define valid contents
  always_ff @(posedge clk_in) begin
    if (rx_push_s) begin
      rx_mem_q[rx_wp_q] <= bus.rx_data;
    end
    if (tx_push_s) begin
      tx_mem_q[tx_wp_q] <= tx_push_data_s;
    end
  end

  // Next-state for both FIFO pointer sets and occupancy counts
  always_comb begin
    rx_wp_d  = rx_push_s ? rx_wp_q + PTR_ONE : rx_wp_q;
    rx_rp_d  = rx_pop_s  ? rx_rp_q + PTR_ONE : rx_rp_q;
    tx_wp_d  = tx_push_s ? tx_wp_q + PTR_ONE : tx_wp_q;
    tx_rp_d  = tx_pop_s  ? tx_rp_q + PTR_ONE : tx_rp_q;
    case ({rx_push_s, rx_pop_s})
      2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
      2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
      default: rx_cnt_d = rx_cnt_q;
    endcase
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
      2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // Next-state for read data select, I/O read data, snapshot, counter, halt
  always_comb begin
    io_din_d  = io_din_q;
    din_sel_d = din_sel_q;
    snap_d    = snap_q;
    cnt_d     = halt_q ? cnt_q : cnt_q + 32'd1;
    halt_d    = halt_q | (acc_wr_s & is_io_s & (io_off_s == 16'h0004));
    if (acc_rd_s) begin
      if (is_io_s) begin
        din_sel_d = 1'b0;
        case (io_off_s)
          16'h0000: io_din_d = rx_empty_s ? 8'h00 : rx_mem_q[rx_rp_q];
          16'h0004: begin
            io_din_d = cnt_q[7:0];
            snap_d   = cnt_q[31:8];
          end
          16'h0005: io_din_d = snap_q[7:0];
          16'h0006: io_din_d = snap_q[15:8];
          16'h0007: io_din_d = snap_q[23:16];
          default:  io_din_d = 8'h00;
        endcase
      end else begin
        din_sel_d = 1'b1;
      end
    end else begin
      io_din_d  = io_din_q;
      din_sel_d = din_sel_q;
    end
  end

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      cnt_q     <= 32'd0;
      snap_q    <= 24'd0;
      halt_q    <= 1'b0;
      io_din_q  <= 8'h00;
      din_sel_q <= 1'b0;
    end else begin
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      halt_q    <= halt_d;
      io_din_q  <= io_din_d;
      din_sel_q <= din_sel_d;
    end
  end
endmodule
